// File: rtl/port_io_controller.sv
// Port I/O peripheral: buffers processor OUT writes toward an external sink, buffers
// external words toward the processor IN port, and requests an interrupt while input waits.
module port_io_controller #(
  parameter int DATA_W    = 16,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4,
  parameter int IRQ_GAP   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cpu_out_data,
  input  logic              cpu_out_wr,
  output logic [DATA_W-1:0] cpu_in_data,
  output logic              cpu_in_valid,
  input  logic              cpu_in_rd,
  output logic              irq,
  input  logic              irq_ack,
  input  logic              irq_en,
  output logic [DATA_W-1:0] ext_out_data,
  output logic              ext_out_valid,
  input  logic              ext_out_ready,
  input  logic [DATA_W-1:0] ext_in_data,
  input  logic              ext_in_valid,
  output logic              ext_in_ready,
  output logic              out_overflow,
  output logic              in_underflow
);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_CW = OUT_AW + 1;
  localparam int IN_CW  = IN_AW + 1;
  localparam int GAP_W  = $clog2(IRQ_GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} irq_state_t;

  // ---------------- output FIFO (processor -> sink) ----------------
  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wr_ptr_reg, out_rd_ptr_reg;
  logic [OUT_CW-1:0] out_count_reg, out_count_next;
  logic              out_overflow_reg;
  logic              out_full, out_push, out_pop;

  assign ext_out_valid = (out_count_reg != '0);
  assign out_full      = (out_count_reg == OUT_CW'(OUT_DEPTH));
  assign out_pop       = ext_out_valid & ext_out_ready;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign out_push      = cpu_out_wr & (~out_full | out_pop);
  assign ext_out_data  = ext_out_valid ? out_mem[out_rd_ptr_reg] : '0;
  assign out_overflow  = out_overflow_reg;

  always_comb begin
    out_count_next = out_count_reg;
    if (out_push && !out_pop)
      out_count_next = out_count_reg + OUT_CW'(1);
    else if (!out_push && out_pop)
      out_count_next = out_count_reg - OUT_CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_wr_ptr_reg   <= '0;
      out_rd_ptr_reg   <= '0;
      out_count_reg    <= '0;
      out_overflow_reg <= 1'b0;
    end else begin
      if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + OUT_AW'(1);
      if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + OUT_AW'(1);
      out_count_reg <= out_count_next;
      if (cpu_out_wr && out_full && !out_pop) out_overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr_ptr_reg] <= cpu_out_data;
  end

  // ---------------- input FIFO (source -> processor) ----------------
  logic [DATA_W-1:0] in_mem [IN_DEPTH];
  logic [IN_AW-1:0]  in_wr_ptr_reg, in_rd_ptr_reg;
  logic [IN_CW-1:0]  in_count_reg, in_count_next;
  logic              in_underflow_reg;
  logic              in_push, in_pop;

  assign cpu_in_valid = (in_count_reg != '0);
  // Held low during reset so the source never completes a handshake that reset discards.
  assign ext_in_ready = rst & (in_count_reg != IN_CW'(IN_DEPTH));
  assign in_push      = ext_in_valid & ext_in_ready;
  assign in_pop       = cpu_in_rd & cpu_in_valid;
  assign cpu_in_data  = cpu_in_valid ? in_mem[in_rd_ptr_reg] : '0;
  assign in_underflow = in_underflow_reg;

  always_comb begin
    in_count_next = in_count_reg;
    if (in_push && !in_pop)
      in_count_next = in_count_reg + IN_CW'(1);
    else if (!in_push && in_pop)
      in_count_next = in_count_reg - IN_CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_wr_ptr_reg    <= '0;
      in_rd_ptr_reg    <= '0;
      in_count_reg     <= '0;
      in_underflow_reg <= 1'b0;
    end else begin
      if (in_push) in_wr_ptr_reg <= in_wr_ptr_reg + IN_AW'(1);
      if (in_pop)  in_rd_ptr_reg <= in_rd_ptr_reg + IN_AW'(1);
      in_count_reg <= in_count_next;
      if (cpu_in_rd && !cpu_in_valid) in_underflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_ptr_reg] <= ext_in_data;
  end

  // ---------------- interrupt request FSM ----------------
  irq_state_t       irq_state_reg;
  logic             irq_reg;
  logic [GAP_W-1:0] gap_cnt_reg;

  assign irq = irq_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_state_reg <= S_IDLE;
      irq_reg       <= 1'b0;
      gap_cnt_reg   <= '0;
    end else begin
      case (irq_state_reg)
        S_IDLE: begin
          if (irq_en && cpu_in_valid) begin
            irq_state_reg <= S_REQ;
            irq_reg       <= 1'b1;
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            irq_state_reg <= S_GAP;
            irq_reg       <= 1'b0;
            gap_cnt_reg   <= GAP_W'(IRQ_GAP);
          end
        end
        S_GAP: begin
          gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
          // The edge that expires the holdoff also performs the idle check, keeping irq
          // low for exactly IRQ_GAP cycles when data is still waiting.
          if (gap_cnt_reg == GAP_W'(1)) begin
            if (irq_en && cpu_in_valid) begin
              irq_state_reg <= S_REQ;
              irq_reg       <= 1'b1;
            end else begin
              irq_state_reg <= S_IDLE;
            end
          end
        end
        default: begin
          irq_state_reg <= S_IDLE;
          irq_reg       <= 1'b0;
        end
      endcase
    end
  end

endmodule
